// File: rtl/eeprom_burst_ctrl.sv
// eeprom_burst_ctrl: splits 1..MAX_LEN byte EEPROM bursts into single-byte
// IIC driver transactions, with write-cycle wait and NACK retry.
module eeprom_burst_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'b101_0000,
  parameter int ADDR_W = 16,
  parameter int MAX_LEN = 32,
  parameter int LEN_W = 6,
  parameter int TWR_CYCLES = 5000,
  parameter int RETRY_MAX = 7
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Rh_wl,
  input  logic [ADDR_W-1:0] Start_addr,
  input  logic [LEN_W-1:0]  Len,
  output logic              Wr_req,
  input  logic [7:0]        Wr_data,
  output logic              Rd_valid,
  output logic [7:0]        Rd_data,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [LEN_W-1:0]  Byte_cnt,
  output logic              Drv_en,
  output logic              Drv_rh_wl,
  output logic [6:0]        Drv_slave_addr,
  output logic [15:0]       Drv_addr,
  output logic              Drv_bit_sel,
  output logic [7:0]        Drv_wdata,
  input  logic [7:0]        Drv_rdata,
  input  logic              Drv_done,
  input  logic              Drv_ack_err
);

  localparam int TW_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
  localparam int RT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_TWR,
    S_RETRY_WAIT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic              rh_wl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        wdata_q;
  logic [TW_W-1:0]   tw_q;
  logic [RT_W-1:0]   retry_q;
  logic              fail_q;

  logic             accept;
  logic             len_bad;
  logic             xfer_ok;
  logic             xfer_nack;
  logic             can_retry;
  logic             tw_last;
  logic             waiting;
  logic [LEN_W-1:0] cnt_inc;

  // A Start coinciding with Done is dropped so the caller sees Busy low first
  assign accept    = (state_q == S_IDLE) && Start && !Done;
  assign len_bad   = (Len == '0) || (Len > LEN_W'(MAX_LEN));
  assign xfer_ok   = (state_q == S_WAIT_DONE) && Drv_done && !Drv_ack_err;
  assign xfer_nack = (state_q == S_WAIT_DONE) && Drv_done && Drv_ack_err;
  assign can_retry = retry_q < RT_W'(RETRY_MAX);
  assign tw_last   = tw_q == TW_W'(TWR_CYCLES - 1);
  assign waiting   = (state_q == S_TWR) || (state_q == S_RETRY_WAIT);
  assign cnt_inc   = Byte_cnt + 1'b1;

  assign Drv_slave_addr = SLAVE_ADDR;
  assign Drv_bit_sel    = (ADDR_W == 16);
  assign Drv_addr       = 16'(addr_q);
  assign Drv_rh_wl      = rh_wl_q;
  assign Drv_wdata      = wdata_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    Wr_req  = 1'b0;
    Drv_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (len_bad) begin
            state_d = S_FINISH;
          end else if (Rh_wl) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        Wr_req  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        Drv_en  = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (xfer_ok) begin
          if (!rh_wl_q) begin
            state_d = S_TWR;
          end else if (cnt_inc == len_q) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (xfer_nack) begin
          state_d = can_retry ? S_RETRY_WAIT : S_FINISH;
        end
      end
      S_TWR: begin
        if (tw_last) begin
          state_d = (Byte_cnt == len_q) ? S_FINISH : S_FETCH;
        end
      end
      S_RETRY_WAIT: begin
        if (tw_last) begin
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rh_wl_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      tw_q     <= '0;
      retry_q  <= '0;
      fail_q   <= 1'b0;
      Rd_valid <= 1'b0;
      Rd_data  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Byte_cnt <= '0;
    end else begin
      Rd_valid <= 1'b0;
      Done     <= 1'b0;
      if (accept) begin
        rh_wl_q  <= Rh_wl;
        addr_q   <= Start_addr;
        len_q    <= Len;
        retry_q  <= '0;
        fail_q   <= len_bad;
        Byte_cnt <= '0;
        Busy     <= 1'b1;
        Err      <= 1'b0;
      end
      if (Wr_req) begin
        wdata_q <= Wr_data;
      end
      if (xfer_ok) begin
        Byte_cnt <= cnt_inc;
        addr_q   <= addr_q + 1'b1;
        retry_q  <= '0;
        if (rh_wl_q) begin
          Rd_data  <= Drv_rdata;
          Rd_valid <= 1'b1;
        end
      end
      if (xfer_nack) begin
        if (can_retry) begin
          retry_q <= retry_q + 1'b1;
        end else begin
          fail_q <= 1'b1;
        end
      end
      // One counter times both the write cycle and the retry back-off
      if (waiting && !tw_last) begin
        tw_q <= tw_q + 1'b1;
      end else begin
        tw_q <= '0;
      end
      if (state_q == S_FINISH) begin
        Done <= 1'b1;
        Busy <= 1'b0;
        Err  <= fail_q;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_burst_ctrl.sv
// tb_eeprom_burst_ctrl: directed bursts against an EEPROM/driver model
// with a per-cycle compare process and literal spot checks.
module tb_eeprom_burst_ctrl;

  localparam int TW = 16;
  localparam int RMAX = 7;
  localparam int MLEN = 32;

  typedef struct {
    bit          rh;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          gap;
  } tx_t;

  logic clk, rst_n, sel8;
  logic start, rh_wl;
  logic [15:0] start_addr;
  logic [5:0] len_in;
  logic [7:0] wr_data;
  logic [7:0] drv_rdata;
  logic drv_done, drv_ack_err;

  logic s16, s8, dd16, dd8;
  logic wrq16, rv16, busy16, done16, err16, en16, rh16, bs16;
  logic wrq8, rv8, busy8, done8, err8, en8, rh8, bs8;
  logic [7:0] rd16, wd16, rd8, wd8;
  logic [5:0] bc16, bc8;
  logic [6:0] sa16, sa8;
  logic [15:0] a16, a8;

  logic m_wr_req, m_rd_valid, m_busy, m_done, m_err, m_drv_en, m_drv_rh;
  logic [7:0] m_rd_data, m_drv_wdata;
  logic [5:0] m_byte_cnt;
  logic [15:0] m_drv_addr;

  assign s16  = start & ~sel8;
  assign s8   = start & sel8;
  assign dd16 = drv_done & ~sel8;
  assign dd8  = drv_done & sel8;

  assign m_wr_req    = sel8 ? wrq8 : wrq16;
  assign m_rd_valid  = sel8 ? rv8 : rv16;
  assign m_rd_data   = sel8 ? rd8 : rd16;
  assign m_busy      = sel8 ? busy8 : busy16;
  assign m_done      = sel8 ? done8 : done16;
  assign m_err       = sel8 ? err8 : err16;
  assign m_byte_cnt  = sel8 ? bc8 : bc16;
  assign m_drv_en    = sel8 ? en8 : en16;
  assign m_drv_rh    = sel8 ? rh8 : rh16;
  assign m_drv_addr  = sel8 ? a8 : a16;
  assign m_drv_wdata = sel8 ? wd8 : wd16;

  eeprom_burst_ctrl #(
    .ADDR_W(16), .MAX_LEN(MLEN), .LEN_W(6),
    .TWR_CYCLES(TW), .RETRY_MAX(RMAX)
  ) dut16 (
    .Clk(clk), .Rst_n(rst_n), .Start(s16), .Rh_wl(rh_wl),
    .Start_addr(start_addr), .Len(len_in),
    .Wr_req(wrq16), .Wr_data(wr_data),
    .Rd_valid(rv16), .Rd_data(rd16),
    .Busy(busy16), .Done(done16), .Err(err16), .Byte_cnt(bc16),
    .Drv_en(en16), .Drv_rh_wl(rh16), .Drv_slave_addr(sa16),
    .Drv_addr(a16), .Drv_bit_sel(bs16), .Drv_wdata(wd16),
    .Drv_rdata(drv_rdata), .Drv_done(dd16), .Drv_ack_err(drv_ack_err)
  );

  eeprom_burst_ctrl #(
    .ADDR_W(8), .MAX_LEN(MLEN), .LEN_W(6),
    .TWR_CYCLES(TW), .RETRY_MAX(RMAX)
  ) dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(s8), .Rh_wl(rh_wl),
    .Start_addr(start_addr[7:0]), .Len(len_in),
    .Wr_req(wrq8), .Wr_data(wr_data),
    .Rd_valid(rv8), .Rd_data(rd8),
    .Busy(busy8), .Done(done8), .Err(err8), .Byte_cnt(bc8),
    .Drv_en(en8), .Drv_rh_wl(rh8), .Drv_slave_addr(sa8),
    .Drv_addr(a8), .Drv_bit_sel(bs8), .Drv_wdata(wd8),
    .Drv_rdata(drv_rdata), .Drv_done(dd8), .Drv_ack_err(drv_ack_err)
  );

  int n_cmp, n_bad, cyc, ref_cyc, widx, drv_lat;
  int obs_en, obs_wreq;
  logic [7:0] mem [0:65535];
  logic [7:0] src [0:63];
  tx_t exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] obs_rd[$];
  logic [15:0] obs_addr[$];
  bit nack_model[$];
  bit nack_drv[$];
  bit nack_always, exp_err, exp_done_pend, done_seen, drv_busy, in_txn;
  int exp_cnt, exp_wreq, exp_done_gap;
  logic [15:0] cur_addr;
  logic [7:0] cur_wd;
  logic cur_rh;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected transaction list derived from the burst rules
  task automatic plan(bit rh, int a0, int len, int aw);
    logic [15:0] a;
    int mask, retries, k, gap;
    bit nk;
    tx_t t;
    a = 16'(a0);
    mask = (1 << aw) - 1;
    k = 0;
    exp_tx.delete();
    exp_rd.delete();
    exp_err = 0;
    exp_cnt = 0;
    exp_wreq = 0;
    exp_done_gap = 2;
    if (len == 0 || len > MLEN) begin
      exp_err = 1;
      return;
    end
    gap = rh ? 1 : 2;
    for (int i = 0; i < len; i++) begin
      retries = 0;
      if (!rh) exp_wreq++;
      while (1) begin
        t.rh = rh;
        t.addr = a;
        t.wd = rh ? 8'h00 : src[widx + i];
        t.gap = gap;
        exp_tx.push_back(t);
        nk = nack_always || (k < nack_model.size() && nack_model[k]);
        k++;
        if (!nk) break;
        if (retries == RMAX) begin
          exp_err = 1;
          exp_cnt = i;
          exp_done_gap = 2;
          return;
        end
        retries++;
        gap = TW + 1;
      end
      if (rh) exp_rd.push_back(mem[a]);
      exp_cnt = i + 1;
      a = 16'((int'(a) + 1) & mask);
      gap = rh ? 1 : TW + 2;
    end
    exp_done_gap = rh ? 2 : TW + 2;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // EEPROM + single-byte driver model
  initial begin
    logic [15:0] a;
    logic [7:0] wd;
    logic rh;
    bit nk;
    drv_done = 0;
    drv_ack_err = 0;
    drv_rdata = 0;
    drv_busy = 0;
    forever begin
      @(negedge clk);
      if (rst_n && m_drv_en) begin
        a = m_drv_addr;
        wd = m_drv_wdata;
        rh = m_drv_rh;
        nk = nack_always;
        if (nack_drv.size() > 0) begin
          if (nack_drv.pop_front()) nk = 1;
        end
        drv_busy = 1;
        repeat (drv_lat) @(posedge clk);
        #1;
        drv_done = 1;
        drv_ack_err = nk;
        drv_rdata = (rh && !nk) ? mem[a] : 8'hEE;
        if (!nk && !rh) mem[a] = wd;
        @(posedge clk);
        #1;
        drv_done = 0;
        drv_ack_err = 0;
        drv_busy = 0;
      end
    end
  end

  // Show-ahead write-data source
  initial begin
    forever begin
      @(negedge clk);
      if (m_wr_req) begin
        @(posedge clk);
        #1;
        widx++;
        wr_data = src[widx];
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    tx_t t;
    in_txn = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0;
        chk("rst_quiet", {m_busy, m_drv_en, m_done, m_rd_valid, m_wr_req}, 0);
      end else begin
        if (m_drv_en) begin
          obs_en++;
          obs_addr.push_back(m_drv_addr);
          if (exp_tx.size() == 0) begin
            chk("drv_en_unexp", 1, 0);
          end else begin
            t = exp_tx.pop_front();
            chk("drv_addr", m_drv_addr, t.addr);
            chk("drv_rh", m_drv_rh, t.rh);
            if (!t.rh) chk("drv_wdata", m_drv_wdata, t.wd);
            chk("drv_en_gap", cyc - ref_cyc, t.gap);
          end
          chk("busy_on_en", m_busy, 1);
          cur_addr = m_drv_addr;
          cur_wd = m_drv_wdata;
          cur_rh = m_drv_rh;
          in_txn = 1;
        end
        if (drv_done && in_txn) begin
          chk("hold_addr", m_drv_addr, cur_addr);
          chk("hold_wdata", m_drv_wdata, cur_wd);
          chk("hold_rh", m_drv_rh, cur_rh);
          ref_cyc = cyc;
          in_txn = 0;
        end
        if (m_wr_req) obs_wreq++;
        if (m_rd_valid) begin
          obs_rd.push_back(m_rd_data);
          if (exp_rd.size() == 0) chk("rd_unexp", 1, 0);
          else chk("rd_data", m_rd_data, exp_rd.pop_front());
        end
        if (m_done) begin
          if (!exp_done_pend) begin
            chk("done_unexp", 1, 0);
          end else begin
            chk("done_gap", cyc - ref_cyc, exp_done_gap);
            chk("done_err", m_err, exp_err);
            chk("done_cnt", m_byte_cnt, exp_cnt);
            chk("busy_at_done", m_busy, 0);
            exp_done_pend = 0;
          end
          done_seen = 1;
        end
      end
    end
  end

  task automatic launch(bit use8, bit rh, int a0, int len);
    sel8 = use8;
    plan(rh, a0, len, use8 ? 8 : 16);
    nack_drv = nack_model;
    obs_rd.delete();
    obs_addr.delete();
    obs_en = 0;
    obs_wreq = 0;
    done_seen = 0;
    exp_done_pend = 1;
    @(posedge clk);
    #1;
    start = 1;
    rh_wl = rh;
    start_addr = 16'(a0);
    len_in = 6'(len);
    ref_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic burst(bit use8, bit rh, int a0, int len, int poke);
    launch(use8, rh, a0, len);
    for (int i = 1; i <= 2000; i++) begin
      if (i == poke) begin
        start = 1;
        rh_wl = 1;
        start_addr = 16'h0200;
        len_in = 6'd1;
      end
      @(posedge clk);
      #1;
      start = 0;
      if (done_seen) break;
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("tx_left", exp_tx.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("wreq_cnt", obs_wreq, exp_wreq);
    nack_model.delete();
    nack_always = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 0;
    sel8 = 0;
    start = 0;
    rh_wl = 0;
    start_addr = 0;
    len_in = 0;
    nack_always = 0;
    exp_done_pend = 0;
    drv_lat = 3;
    widx = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 64; i++) src[i] = 8'hA0 + 8'(i);
    wr_data = src[0];

    @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_err", err16, 0);
    chk("rst_cnt", bc16, 0);
    chk("rst_addr", a16, 0);
    chk("rst_wdata", wd16, 0);
    chk("rst_rdata", rd16, 0);
    chk("rst_rh", rh16, 0);
    chk("slave_addr", sa16, 7'h50);
    chk("bit_sel16", bs16, 1);
    chk("bit_sel8", bs8, 0);
    chk("rst_addr8", a8, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    burst(0, 0, 'h0010, 4, 0);
    chk("w4_en", obs_en, 4);
    chk("w4_wreq", obs_wreq, 4);
    chk("w4_cnt", m_byte_cnt, 4);
    chk("w4_err", m_err, 0);
    chk("w4_mem0", mem[16'h0010], 8'hA0);
    chk("w4_mem3", mem[16'h0013], 8'hA3);

    burst(0, 1, 'h0010, 4, 0);
    chk("r4_n", obs_rd.size(), 4);
    for (int i = 0; i < 4 && i < obs_rd.size(); i++)
      chk("r4_data", obs_rd[i], 8'hA0 + 8'(i));
    chk("r4_err", m_err, 0);

    burst(0, 1, 'hFFFE, 3, 0);
    chk("wrap16_n", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      chk("wrap16_a1", obs_addr[1], 16'hFFFF);
      chk("wrap16_a2", obs_addr[2], 16'h0000);
    end

    burst(1, 1, 'h00FF, 2, 0);
    chk("wrap8_n", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("wrap8_a0", obs_addr[0], 16'h00FF);
      chk("wrap8_a1", obs_addr[1], 16'h0000);
    end
    chk("wrap8_rd1", obs_rd.size() > 1 ? obs_rd[1] : 8'hXX, 8'h5A);

    nack_model = '{1, 1};
    burst(0, 0, 'h0100, 2, 0);
    chk("retry_en", obs_en, 4);
    chk("retry_wreq", obs_wreq, 2);
    chk("retry_err", m_err, 0);
    chk("retry_cnt", m_byte_cnt, 2);
    if (obs_addr.size() >= 3) chk("retry_same", obs_addr[2], 16'h0100);
    chk("retry_mem", mem[16'h0101], 8'hA5);

    nack_always = 1;
    burst(0, 0, 'h0200, 3, 0);
    chk("nack_en", obs_en, 8);
    chk("nack_err", m_err, 1);
    chk("nack_cnt", m_byte_cnt, 0);

    burst(0, 0, 'h0300, 0, 2);
    chk("len0_err", m_err, 1);
    chk("len0_en", obs_en, 0);

    burst(0, 1, 'h0300, 33, 0);
    chk("len33_err", m_err, 1);
    chk("len33_en", obs_en, 0);

    burst(0, 0, 'h0400, 2, 5);
    chk("poke_en", obs_en, 2);
    chk("poke_err", m_err, 0);

    drv_lat = 12;
    launch(0, 1, 'h0040, 2);
    for (int i = 0; i < 50 && obs_en == 0; i++) @(posedge clk);
    chk("rst_mid_en", obs_en, 1);
    repeat (3) @(posedge clk);
    #1;
    exp_tx.delete();
    exp_rd.delete();
    exp_done_pend = 0;
    rst_n = 0;
    @(negedge clk);
    chk("mid_busy", m_busy, 0);
    chk("mid_en", m_drv_en, 0);
    chk("mid_cnt", m_byte_cnt, 0);
    chk("mid_err", m_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 50 && drv_busy; i++) @(posedge clk);
    chk("drv_idle", drv_busy, 0);
    repeat (3) @(posedge clk);
    drv_lat = 3;
    burst(0, 1, 'h0040, 2, 0);
    chk("post_rst_n", obs_rd.size(), 2);
    chk("post_rst_d0", obs_rd.size() > 0 ? obs_rd[0] : 8'hXX, 8'h1A);
    chk("post_rst_err", m_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
